// File: rtl/dcpu16_mem_arb_if.sv
// ---------------------------------------------------------------------------
// dcpu16_mem_arb_if
// Bundles every signal around the DCPU-16 memory arbiter: the core's
// instruction-fetch port (f_*), its data port (g_*), the shared memory bus
// (wb_*) and the status outputs ena/err.
//
// Modports:
//   slave  - the arbiter's view. It serves the two core ports, drives the
//            shared bus and reports ena/err.
//   master - the environment's view. The core issues requests on f_*/g_*
//            and the memory answers on wb_dti/wb_ack.
// ---------------------------------------------------------------------------
interface dcpu16_mem_arb_if;
  // instruction-fetch port
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_ack;
  logic [15:0] f_dti;
  // data port
  logic [15:0] g_adr;
  logic        g_stb;
  logic        g_wre;
  logic [15:0] g_dto;
  logic        g_ack;
  logic [15:0] g_dti;
  // shared memory bus
  logic [15:0] wb_adr;
  logic [15:0] wb_dto;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [15:0] wb_dti;
  logic        wb_ack;
  // status
  logic        ena;
  logic        err;

  modport slave (
    input  f_adr, f_stb, g_adr, g_stb, g_wre, g_dto, wb_dti, wb_ack,
    output f_ack, f_dti, g_ack, g_dti,
           wb_adr, wb_dto, wb_we, wb_stb, wb_cyc, ena, err
  );

  modport master (
    output f_adr, f_stb, g_adr, g_stb, g_wre, g_dto, wb_dti, wb_ack,
    input  f_ack, f_dti, g_ack, g_dti,
           wb_adr, wb_dto, wb_we, wb_stb, wb_cyc, ena, err
  );
endinterface : dcpu16_mem_arb_if

// File: rtl/dcpu16_mem_arb.sv
// ---------------------------------------------------------------------------
// dcpu16_mem_arb
// Shares one memory bus between the DCPU-16 fetch port and data port.
// The data port has priority. A fetch that has waited through two data
// grants in a row is served next. Every transfer is bounded by a wait
// counter. A transfer that times out completes with zero data and sets
// a sticky error flag.
//
// Parameters:
//   TMO  - bus-timeout limit in cycles (1..15)
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - dcpu16_mem_arb_if.slave: f_* fetch port, g_* data port,
//          wb_* shared bus master side, ena core clock-enable, err flag
// ---------------------------------------------------------------------------
module dcpu16_mem_arb #(
  parameter int unsigned TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  dcpu16_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FBUS = 2'd1,
    GBUS = 2'd2
  } state_e;

  localparam logic [3:0] TMO_W = 4'(TMO);

  state_e      state_q, state_d;
  logic [1:0]  fair_q,  fair_d;   // data grants in a row with a fetch waiting
  logic [3:0]  wait_q,  wait_d;   // bus cycles without wb_ack
  logic        err_q,   err_d;
  logic        f_ack_q, f_ack_d;
  logic        g_ack_q, g_ack_d;
  logic [15:0] f_dti_q, f_dti_d;
  logic [15:0] g_dti_q, g_dti_d;
  logic [15:0] wb_adr_q, wb_adr_d;
  logic [15:0] wb_dto_q, wb_dto_d;
  logic        wb_we_q,  wb_we_d;

  logic        f_elig;
  logic        g_elig;
  logic        turnaround;
  logic        fetch_due;
  logic [3:0]  wait_inc;

  // A port whose ack is high this cycle is finishing. Its stb may still
  // be high, so it must not be granted again.
  assign f_elig     = bus.f_stb & ~f_ack_q;
  assign g_elig     = bus.g_stb & ~g_ack_q;
  // In the ack cycle the requester is still presenting the old request.
  // No decision is made until the cycle after.
  assign turnaround = f_ack_q | g_ack_q;
  assign fetch_due  = (fair_q == 2'd2) && f_elig;
  assign wait_inc   = wait_q + 4'd1;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) here so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      fair_q   <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      f_ack_q  <= 1'b0;
      g_ack_q  <= 1'b0;
      f_dti_q  <= '0;
      g_dti_q  <= '0;
      wb_adr_q <= '0;
      wb_dto_q <= '0;
      wb_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fair_q   <= fair_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      f_ack_q  <= f_ack_d;
      g_ack_q  <= g_ack_d;
      f_dti_q  <= f_dti_d;
      g_dti_q  <= g_dti_d;
      wb_adr_q <= wb_adr_d;
      wb_dto_q <= wb_dto_d;
      wb_we_q  <= wb_we_d;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    fair_d   = fair_q;
    wait_d   = wait_q;
    err_d    = err_q;
    f_ack_d  = 1'b0;
    g_ack_d  = 1'b0;
    f_dti_d  = f_dti_q;
    g_dti_d  = g_dti_q;
    wb_adr_d = wb_adr_q;
    wb_dto_d = wb_dto_q;
    wb_we_d  = wb_we_q;

    case (state_q)
      IDLE: begin
        // wb_ack is not looked at here, so a stray slave ack is ignored.
        if (!turnaround) begin
          if (g_elig && !fetch_due) begin
            state_d  = GBUS;
            wb_adr_d = bus.g_adr;
            wb_dto_d = bus.g_dto;
            wb_we_d  = bus.g_wre;
            wait_d   = '0;
            // The count only runs while the fetch keeps losing.
            fair_d   = f_elig ? fair_q + 2'd1 : 2'd0;
          end else if (f_elig) begin
            state_d  = FBUS;
            wb_adr_d = bus.f_adr;
            wb_dto_d = '0;
            wb_we_d  = 1'b0;
            wait_d   = '0;
            fair_d   = '0;
          end
        end
      end

      FBUS, GBUS: begin
        if (bus.wb_ack) begin
          state_d = IDLE;
          if (state_q == GBUS) begin
            g_ack_d = 1'b1;
            g_dti_d = bus.wb_dti;
          end else begin
            f_ack_d = 1'b1;
            f_dti_d = bus.wb_dti;
          end
        end else if (wait_inc == TMO_W) begin
          // Timeout: release the bus and finish the request with zero data.
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == GBUS) begin
            g_ack_d = 1'b1;
            g_dti_d = '0;
          end else begin
            f_ack_d = 1'b1;
            f_dti_d = '0;
          end
        end else begin
          wait_d = wait_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.f_ack  = f_ack_q;
  assign bus.f_dti  = f_dti_q;
  assign bus.g_ack  = g_ack_q;
  assign bus.g_dti  = g_dti_q;
  assign bus.wb_adr = wb_adr_q;
  assign bus.wb_dto = wb_dto_q;
  assign bus.wb_we  = wb_we_q;
  assign bus.wb_stb = (state_q != IDLE);
  assign bus.wb_cyc = (state_q != IDLE);
  assign bus.err    = err_q;
  // Stall the core while either port has a request that is not finishing.
  assign bus.ena    = ~((bus.f_stb & ~f_ack_q) | (bus.g_stb & ~g_ack_q));

endmodule : dcpu16_mem_arb

// File: doc/dcpu16_mem_arb.md
DCPU16_MEM_ARB -- requirements
Module: dcpu16_mem_arb

Interface
REQ-001 SHALL have parameter TMO, default 15, meaning the bus-timeout limit in cycles (range 1..15).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-004 SHALL have port f_adr  in  16  instruction-fetch address.
REQ-005 SHALL have port f_stb  in  1  fetch request; held high until f_ack.
REQ-006 SHALL have port f_ack  out  1  fetch done, one-cycle pulse.
REQ-007 SHALL have port f_dti  out  16  fetch read data, valid while f_ack=1.
REQ-008 SHALL have port g_adr  in  16  data-port address.
REQ-009 SHALL have port g_stb  in  1  data request; held high until g_ack.
REQ-010 SHALL have port g_wre  in  1  data-port write enable.
REQ-011 SHALL have port g_dto  in  16  data-port write data.
REQ-012 SHALL have port g_ack  out  1  data done, one-cycle pulse.
REQ-013 SHALL have port g_dti  out  16  data-port read data, valid while g_ack=1.
REQ-014 SHALL have ports wb_adr out 16, wb_dto out 16, wb_we out 1, wb_stb out 1, wb_cyc out 1: shared memory bus master outputs.
REQ-015 SHALL have ports wb_dti in 16, wb_ack in 1: shared memory bus slave responses.
REQ-016 SHALL have port ena  out  1  core clock-enable; low while any request is outstanding.
REQ-017 SHALL have port err  out  1  sticky bus-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, FBUS, GBUS.
REQ-019 IDLE: grant the data port when g_stb is eligible, else fetch when f_stb is eligible; move to GBUS/FBUS next cycle.
REQ-020 Fairness: after 2 consecutive data grants with f_stb pending at each grant, the next IDLE decision SHALL grant fetch; a fetch grant clears the count.
REQ-021 A port SHALL be ineligible in the cycle its ack is high, so a stb held into the ack cycle is never granted twice.
REQ-022 On grant, wb_adr, wb_dto and wb_we SHALL be registered from the granted port (wb_we=0, wb_dto=0 for fetch) and held constant until bus release.
REQ-023 wb_stb and wb_cyc SHALL be high in FBUS/GBUS and low in IDLE.
REQ-024 On wb_ack=1 in FBUS/GBUS: capture wb_dti, pulse the owning port's ack next cycle with the captured data on its dti, return to IDLE.
REQ-025 A 4-bit wait counter SHALL clear on grant and increment each bus cycle without wb_ack.
REQ-026 If the counter reaches TMO without wb_ack: release the bus, pulse the owning ack with dti=16'h0000, set err, return to IDLE.
REQ-027 err SHALL stay set until rst.
REQ-028 wb_ack while in IDLE SHALL be ignored.
REQ-029 Minimum latency SHALL be 3 cycles from stb to ack with a zero-wait slave (grant, bus cycle, ack); back-to-back grants SHALL be possible on the cycle after an ack.
REQ-030 ena SHALL equal NOT((f_stb AND NOT f_ack) OR (g_stb AND NOT g_ack)), combinational.
REQ-031 f_dti/g_dti SHALL hold their last value when the corresponding ack is low.

Reset
REQ-032 rst SHALL force IDLE, fairness and wait counters to 0, err=0, f_ack=g_ack=0, wb_stb=wb_cyc=wb_we=0, wb_adr=wb_dto=0, f_dti=g_dti=0.
REQ-033 rst during FBUS/GBUS SHALL abandon the transfer: no ack is issued and the bus is released on the next cycle.

Verification
REQ-034 f_stb=1, f_adr=16'h0010, slave acks on its first bus cycle with 16'h7C01 -> wb_adr=16'h0010 and wb_we=0, f_ack pulses 3 cycles after stb with f_dti=16'h7C01, ena=0 until that cycle.
REQ-035 f_stb and g_stb rise together, g_wre=1, g_adr=16'h8000, g_dto=16'hBEEF -> data transfer runs first with wb_we=1, fetch is granted the cycle after g_ack.
REQ-036 f_stb held high while g_stb issues 3 back-to-back requests -> grant order G, G, F, G.
REQ-037 Slave never acks, TMO=15 -> f_ack pulses with f_dti=16'h0000 after 15 wait cycles, err=1 and stays 1 until rst.
REQ-038 rst asserted mid-GBUS with 3 wait cycles elapsed -> no g_ack, wb_cyc=0 next cycle, all outputs at reset values.
REQ-039 Requester holds g_stb through the g_ack cycle then drops it -> exactly one bus transfer, no second grant.
